// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants, state enum and MEM/WB register type for the memory stage
package mem_stage_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - memory/write-back pipeline register with bubble load
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic              reg_write_i,
  input  logic [REG_W-1:0]  dst_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              reg_write_o,
  output logic [REG_W-1:0]  dst_o,
  output logic [DATA_W-1:0] data_o
);

  mem_wb_t wb_q;
  mem_wb_t wb_d;

  always_comb begin
    wb_d = MEM_WB_BUBBLE;
    if (!bubble_i) begin
      wb_d.valid     = valid_i;
      wb_d.reg_write = reg_write_i;
      wb_d.dst       = dst_i;
      wb_d.data      = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= MEM_WB_BUBBLE;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign valid_o     = wb_q.valid;
  assign reg_write_o = wb_q.reg_write;
  assign dst_o       = wb_q.dst;
  assign data_o      = wb_q.data;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: load/store handshake, stall, timeout, store-data forwarding
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [REG_W-1:0]  ex_dst_reg,
  input  logic [REG_W-1:0]  ex_src_reg2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_dst_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  logic              mem_op;
  logic              ack_ok;
  logic              timeout_hit;
  logic              fwd_hit;
  logic              is_load;
  logic              wb_bubble;
  logic              wb_reg_write_in;
  logic [DATA_W-1:0] wb_data_in;

  assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write);
  assign mem_req  = mem_op & ~rst & ((state_q == IDLE) | (state_q == WAIT));
  assign mem_we   = ex_mem_write;
  assign mem_addr = ex_alu_result;

  // An ack only counts while a request is actually on the bus.
  assign ack_ok      = mem_req & mem_ack;
  assign timeout_hit = (state_q == WAIT) & (wait_cnt_q == CNT_LAST) & ~ack_ok;
  assign stall       = mem_req & ~mem_ack & ~timeout_hit;

  assign fwd_hit   = wb_reg_write & wb_valid & (wb_dst_reg == ex_src_reg2) & (ex_src_reg2 != '0);
  assign mem_wdata = fwd_hit ? wb_data : ex_data;

  // Read+write together is a store, so a store never produces a load result.
  assign is_load         = ex_mem_read & ~ex_mem_write;
  assign wb_reg_write_in = ex_reg_write & ex_valid & ~ex_mem_write;
  assign wb_data_in      = is_load ? mem_rdata : ex_alu_result;
  assign wb_bubble       = stall | timeout_hit;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (mem_req && !mem_ack) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (ack_ok) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

  mem_wb_reg u_mem_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .bubble_i    (wb_bubble),
    .valid_i     (ex_valid),
    .reg_write_i (wb_reg_write_in),
    .dst_i       (ex_dst_reg),
    .data_i      (wb_data_in),
    .valid_o     (wb_valid),
    .reg_write_o (wb_reg_write),
    .dst_o       (wb_dst_reg),
    .data_o      (wb_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [15:0] ex_alu_result, ex_data;
  logic [3:0]  ex_dst_reg, ex_src_reg2;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, stall;
  logic        wb_valid, wb_reg_write;
  logic [3:0]  wb_dst_reg;
  logic [15:0] wb_data;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_alu_result(ex_alu_result), .ex_data(ex_data),
    .ex_dst_reg(ex_dst_reg), .ex_src_reg2(ex_src_reg2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dst_reg(wb_dst_reg),
    .wb_data(wb_data), .err(err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1ns so drives/checks happen away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic rw,
                        input logic [15:0] alu, input logic [15:0] d,
                        input logic [3:0] dst, input logic [3:0] src);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
    ex_alu_result = alu; ex_data = d; ex_dst_reg = dst; ex_src_reg2 = src;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
    set_op(1, 1, 0, 1, 16'h0040, 16'h0, 4'd2, 4'd0);
    #2;
    check("rst_mem_req", {15'b0, mem_req}, 16'h0);
    check("rst_stall", {15'b0, stall}, 16'h0);
    tick(); tick();
    check("rst_wb_valid", {15'b0, wb_valid}, 16'h0);
    check("rst_wb_data", wb_data, 16'h0);
    check("rst_err", {15'b0, err}, 16'h0);

    // ALU op
    rst = 1'b0;
    set_op(1, 0, 0, 1, 16'h1234, 16'h0, 4'd3, 4'd0);
    #1;
    check("alu_stall", {15'b0, stall}, 16'h0);
    check("alu_mem_req", {15'b0, mem_req}, 16'h0);
    tick();
    check("alu_wb_data", wb_data, 16'h1234);
    check("alu_wb_dst", {12'b0, wb_dst_reg}, 16'h3);
    check("alu_wb_rw", {15'b0, wb_reg_write}, 16'h1);

    // LW, ack after 2 cycles
    set_op(1, 1, 0, 1, 16'h0040, 16'h0, 4'd4, 4'd0);
    #1;
    check("lw2_req", {15'b0, mem_req}, 16'h1);
    check("lw2_addr", mem_addr, 16'h0040);
    check("lw2_we", {15'b0, mem_we}, 16'h0);
    check("lw2_stall0", {15'b0, stall}, 16'h1);
    tick();
    check("lw2_bubble0", {15'b0, wb_valid}, 16'h0);
    check("lw2_stall1", {15'b0, stall}, 16'h1);
    tick();
    check("lw2_bubble1", {15'b0, wb_valid}, 16'h0);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    check("lw2_stall_ack", {15'b0, stall}, 16'h0);
    tick();
    mem_ack = 1'b0;
    check("lw2_wb_data", wb_data, 16'hBEEF);
    check("lw2_wb_rw", {15'b0, wb_reg_write}, 16'h1);
    check("lw2_wb_dst", {12'b0, wb_dst_reg}, 16'h4);

    // Write R5, then SW forwarding
    set_op(1, 0, 0, 1, 16'h00AA, 16'h0, 4'd5, 4'd0);
    tick();
    set_op(1, 0, 1, 1, 16'h0050, 16'h1111, 4'd9, 4'd5);
    mem_ack = 1'b1;
    #1;
    check("sw_fwd_wdata", mem_wdata, 16'h00AA);
    check("sw_we", {15'b0, mem_we}, 16'h1);
    check("sw_stall", {15'b0, stall}, 16'h0);
    ex_src_reg2 = 4'd6;
    #1;
    check("sw_nofwd_wdata", mem_wdata, 16'h1111);
    tick();
    mem_ack = 1'b0;
    check("sw_wb_valid", {15'b0, wb_valid}, 16'h1);
    check("sw_wb_rw", {15'b0, wb_reg_write}, 16'h0);

    // R0 is never a forwarding source
    set_op(1, 0, 0, 1, 16'h00BB, 16'h0, 4'd0, 4'd0);
    tick();
    set_op(1, 0, 1, 0, 16'h0052, 16'h1111, 4'd0, 4'd0);
    mem_ack = 1'b1;
    #1;
    check("sw_r0_wdata", mem_wdata, 16'h1111);
    tick();

    // LW, zero-wait
    set_op(1, 1, 0, 1, 16'h0060, 16'h0, 4'd6, 4'd0);
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    #1;
    check("lw0_stall", {15'b0, stall}, 16'h0);
    check("lw0_req", {15'b0, mem_req}, 16'h1);
    tick();
    mem_ack = 1'b0;
    check("lw0_wb_data", wb_data, 16'hCAFE);
    check("lw0_state", {15'b0, dut.state_q}, {15'b0, IDLE});

    // LW, no ack: timeout
    set_op(1, 1, 0, 1, 16'h0070, 16'h0, 4'd7, 4'd0);
    for (int i = 0; i < TO; i++) begin
      #1;
      check($sformatf("to_stall_%0d", i), {15'b0, stall}, 16'h1);
      check($sformatf("to_err_%0d", i), {15'b0, err}, 16'h0);
      tick();
    end
    #1;
    check("to_stall_final", {15'b0, stall}, 16'h0);
    tick();
    check("to_bubble", {15'b0, wb_valid}, 16'h0);
    check("to_err", {15'b0, err}, 16'h1);
    set_op(1, 0, 0, 1, 16'h7777, 16'h0, 4'd7, 4'd0);
    tick();
    check("post_to_wb_data", wb_data, 16'h7777);
    check("post_to_wb_valid", {15'b0, wb_valid}, 16'h1);
    check("err_sticky", {15'b0, err}, 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", {15'b0, err}, 16'h0);

    // Reset in 2nd WAIT cycle, then late ack
    set_op(1, 1, 0, 1, 16'h0080, 16'h0, 4'd8, 4'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rw_req", {15'b0, mem_req}, 16'h0);
    check("rw_stall", {15'b0, stall}, 16'h0);
    tick();
    rst = 1'b0;
    check("rw_wb_valid", {15'b0, wb_valid}, 16'h0);
    check("rw_wb_rw", {15'b0, wb_reg_write}, 16'h0);
    check("rw_wb_dst", {12'b0, wb_dst_reg}, 16'h0);
    check("rw_wb_data", wb_data, 16'h0);
    ex_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    check("late_ack_req", {15'b0, mem_req}, 16'h0);
    tick();
    mem_ack = 1'b0;
    check("late_ack_wb_valid", {15'b0, wb_valid}, 16'h0);
    check("late_ack_wb_rw", {15'b0, wb_reg_write}, 16'h0);
    check("late_ack_state", {15'b0, dut.state_q}, {15'b0, IDLE});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
